fp_exponent_logic: RTL and testbench
====================================

// Module: fp_exponent_logic
// PURPOSE
//   Exponent datapath of the single-precision FP multiply/divide unit.
//   Combines the two biased 8-bit operand exponents into one biased result exponent.
//   sel picks the operation: add for multiply, subtract for divide.
//   The result is registered. It is kept 10-bit signed so that the downstream
//   normalise/round stage can detect overflow and underflow.
// PARAMETERS
//   EXP_W   8    operand exponent width (IEEE-754 single)
//   BIAS    127  exponent bias, equal to 2**(EXP_W-1)-1
//   OUT_W   10   result width, equal to EXP_W+2 (sign bit plus one carry bit)
// PORTS
//   clk   in   1      clock; all state updates on its rising edge
//   arst  in   1      reset, synchronous, active-high
//   eA    in   EXP_W  biased exponent of operand A (unsigned)
//   eB    in   EXP_W  biased exponent of operand B (unsigned)
//   en    in   1      load enable for the result register
//   sel   in   1      0 = multiply, 1 = divide
//   e     out  OUT_W  registered biased result exponent, two's complement
// BEHAVIOUR
//   - Arithmetic is combinational and uses OUT_W-bit signed values.
//     eA and eB are zero-extended to OUT_W bits before use.
//       sel=0 (mul): r = eA + eB - BIAS    range -127..383
//       sel=1 (div): r = eA - eB + BIAS    range -128..382
//     Both ranges fit in 10-bit signed, so no saturation and no wrap-around occur.
//   - Register update at posedge clk, in priority order:
//       1. arst=1        -> e <= 0
//       2. else en=1     -> e <= r
//       3. else          -> e holds its value
//   - Latency: the result appears 1 clock after the edge that samples eA, eB and sel with en=1.
//   - Reset value of e is 0 (10'h000).
//   - arst is synchronous. Its assertion takes effect only at the next posedge.
//     Between edges, e does not change on arst.
//   - arst asserted together with en=1: reset wins, and e=0 after that edge.
//   - Reset mid-stream: any pending result is discarded.
//     e stays 0 until the first edge with arst=0 and en=1.
//   - sel and eA/eB changes while en=0 have no effect on e.
//   - The block has no handshake and no FSM. It accepts a new operation every enabled cycle.
//   - Before the first reset, e is unknown. Benches apply reset first.
//   - The block does not interpret special values (exponent 0 or 255 for zero,
//     denormal, Inf or NaN). Those are flagged elsewhere in the unit.
// TESTING
//   1. Reset: arst=1, en=1, eA=200, eB=100 for 1 edge -> e=10'h000.
//      After arst=0 with en=0, e stays 0.
//   2. Multiply:
//      - sel=0, en=1, eA=127, eB=127 -> e=127 (10'h07F) one clock later.
//      - eA=255, eB=255 -> 383 (10'h17F).
//      - eA=0, eB=0 -> -127 (10'h381).
//   3. Divide:
//      - sel=1, en=1, eA=130, eB=3 -> e=254 (10'h0FE).
//      - eA=0, eB=255 -> -128 (10'h380).
//      - eA=255, eB=0 -> 382 (10'h17E).
//   4. Hold: load e=127, then en=0 with random eA, eB and sel for 10 cycles -> e stays 127.
//   5. Reset priority and mid-stream: arst=1 with en=1 -> e=0 at that edge.
//      Deassert arst with en=1, eA=10, eB=20, sel=0 -> e=-97 (10'h39F) next edge.
//   6. Random: 500 cycles of random en, sel, eA and eB, with two reset pulses of 2-3 cycles.
//      Check e cycle-by-cycle against a reference model of the register equations above.

Source files
------------

// File: rtl/fp_exponent_logic_if.sv
// Operand/result bundle for the FP multiply/divide exponent datapath.
// The master drives the operand exponents and controls; the slave returns the registered exponent.
interface fp_exponent_logic_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned OUT_W = 10
);
    logic [EXP_W-1:0] eA;
    logic [EXP_W-1:0] eB;
    logic             en;
    logic             sel;
    logic [OUT_W-1:0] e;

    modport master (
        output eA,
        output eB,
        output en,
        output sel,
        input  e
    );

    modport slave (
        input  eA,
        input  eB,
        input  en,
        input  sel,
        output e
    );
endinterface

// File: rtl/fp_exponent_logic.sv
// Exponent datapath of the single-precision FP multiply/divide unit: biased add (mul) or
// biased subtract (div) of two 8-bit exponents into a registered 10-bit two's-complement result.
module fp_exponent_logic #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned BIAS  = 127,
    parameter int unsigned OUT_W = 10
) (
    input  logic                  clk,
    input  logic                  arst,
    fp_exponent_logic_if.slave    bus
);

    logic signed [OUT_W-1:0] a_ext;
    logic signed [OUT_W-1:0] b_ext;
    logic signed [OUT_W-1:0] bias_ext;
    logic signed [OUT_W-1:0] r;
    logic        [OUT_W-1:0] e_d;
    logic        [OUT_W-1:0] e_q;

    // Two extra bits (sign + carry) hold the full -128..383 span without wrap-around.
    always_comb begin
        a_ext    = $signed({{(OUT_W-EXP_W){1'b0}}, bus.eA});
        b_ext    = $signed({{(OUT_W-EXP_W){1'b0}}, bus.eB});
        bias_ext = $signed(OUT_W'(BIAS));
        if (bus.sel) begin
            r = a_ext - b_ext + bias_ext;
        end else begin
            r = a_ext + b_ext - bias_ext;
        end
    end

    always_comb begin
        e_d = e_q;
        if (bus.en) begin
            e_d = r;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    assign bus.e = e_q;

endmodule

// File: tb/tb_fp_exponent_logic.sv
// Directed and randomised checks of the registered exponent add/subtract datapath.
module tb_fp_exponent_logic;

    logic clk;
    logic arst;
    int   errors;
    int   checks;
    logic [9:0] exp_e;

    fp_exponent_logic_if #(.EXP_W(8), .OUT_W(10)) bus ();

    fp_exponent_logic #(.EXP_W(8), .BIAS(127), .OUT_W(10)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle 1 time unit past the rising edge.
    task automatic apply(input logic r, input logic en, input logic s,
                         input logic [7:0] a, input logic [7:0] b);
        arst    = r;
        bus.en  = en;
        bus.sel = s;
        bus.eA  = a;
        bus.eB  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        apply(1'b1, 1'b1, 1'b0, 8'd200, 8'd100);
        checks++;
        if (bus.e !== 10'h000) begin
            errors++;
            $display("FAIL reset_value: got %h expected %h", bus.e, 10'h000);
        end
        apply(1'b0, 1'b0, 1'b0, 8'd200, 8'd100);
        checks++;
        if (bus.e !== 10'h000) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", bus.e, 10'h000);
        end
    endtask

    task automatic test_multiply;
        logic [7:0] a_v [3] = '{8'd127, 8'd255, 8'd0};
        logic [7:0] b_v [3] = '{8'd127, 8'd255, 8'd0};
        logic [9:0] x_v [3] = '{10'h07F, 10'h17F, 10'h381};
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b0, a_v[i], b_v[i]);
            checks++;
            if (bus.e !== x_v[i]) begin
                errors++;
                $display("FAIL mul_%0d: eA=%0d eB=%0d got %h expected %h",
                         i, a_v[i], b_v[i], bus.e, x_v[i]);
            end
        end
    endtask

    task automatic test_divide;
        logic [7:0] a_v [3] = '{8'd130, 8'd0, 8'd255};
        logic [7:0] b_v [3] = '{8'd3, 8'd255, 8'd0};
        logic [9:0] x_v [3] = '{10'h0FE, 10'h380, 10'h17E};
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b1, a_v[i], b_v[i]);
            checks++;
            if (bus.e !== x_v[i]) begin
                errors++;
                $display("FAIL div_%0d: eA=%0d eB=%0d got %h expected %h",
                         i, a_v[i], b_v[i], bus.e, x_v[i]);
            end
        end
    endtask

    task automatic test_hold;
        apply(1'b0, 1'b1, 1'b0, 8'd127, 8'd127);
        checks++;
        if (bus.e !== 10'h07F) begin
            errors++;
            $display("FAIL hold_load: got %h expected %h", bus.e, 10'h07F);
        end
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0, 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            checks++;
            if (bus.e !== 10'h07F) begin
                errors++;
                $display("FAIL hold_%0d: got %h expected %h", i, bus.e, 10'h07F);
            end
        end
    endtask

    task automatic test_reset_priority;
        // e is 127 here; asserting arst between edges must not disturb it.
        arst   = 1'b1;
        bus.en = 1'b1;
        #3;
        checks++;
        if (bus.e !== 10'h07F) begin
            errors++;
            $display("FAIL reset_sync: got %h expected %h", bus.e, 10'h07F);
        end
        apply(1'b1, 1'b1, 1'b0, 8'd200, 8'd100);
        checks++;
        if (bus.e !== 10'h000) begin
            errors++;
            $display("FAIL reset_priority: got %h expected %h", bus.e, 10'h000);
        end
        apply(1'b0, 1'b1, 1'b0, 8'd10, 8'd20);
        checks++;
        if (bus.e !== 10'h39F) begin
            errors++;
            $display("FAIL reset_resume: got %h expected %h", bus.e, 10'h39F);
        end
    endtask

    task automatic test_random;
        logic       r, en, s;
        logic [7:0] a, b;
        int         res;
        int         fails_here;
        fails_here = 0;
        exp_e = 10'h39F;
        for (int c = 0; c < 500; c++) begin
            r  = ((c >= 150) && (c < 152)) || ((c >= 350) && (c < 353));
            en = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            res = s ? (int'(a) - int'(b) + 127) : (int'(a) + int'(b) - 127);
            if (r) begin
                exp_e = 10'h000;
            end else if (en) begin
                exp_e = res[9:0];
            end
            apply(r, en, s, a, b);
            checks++;
            if (bus.e !== exp_e) begin
                errors++;
                fails_here++;
                if (fails_here <= 10) begin
                    $display("FAIL random_%0d: arst=%0b en=%0b sel=%0b eA=%0d eB=%0d got %h expected %h",
                             c, r, en, s, a, b, bus.e, exp_e);
                end
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        arst    = 1'b0;
        bus.en  = 1'b0;
        bus.sel = 1'b0;
        bus.eA  = '0;
        bus.eB  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_multiply();
        test_divide();
        test_hold();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
